cur_mb_load_ctrl: RTL and testbench

CUR_MB_LOAD_CTRL -- requirements
Module: cur_mb_load_ctrl

---
 rtl/cur_mb_load_ctrl.sv | 134 +++++++++++++
 tb/tb_cur_mb_load_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cur_mb_load_ctrl.sv
// Current-MB buffer load controller: streams 32-pixel raster lines into the LCU buffer with per-row lane rotation.
// Optional macro CUR_LOAD_CHROMA_EN adds the LOAD_C phase (rows 128..191); without it only the 128 luma rows load.

module cur_mb_lane_sel #(
    parameter int LANE_W = 64,
    parameter int IDX    = 0
) (
    input  logic [3:0][LANE_W-1:0] base,
    input  logic [1:0]             k,
    output logic [LANE_W-1:0]      lane
);
    logic [1:0] src;

    // Rotating right by k lanes means output lane j takes base lane (j+k) mod 4.
    always_comb begin
        src  = 2'(IDX) + k;
        lane = base[src];
    end
endmodule

module cur_mb_load_ctrl #(
    parameter  int PIXEL_W = 8,
    localparam int LINE_W  = 32 * PIXEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    input  logic [LINE_W-1:0] pix_data_i,
    output logic              a_wen_o,
    output logic [7:0]        a_addr_o,
    output logic [LINE_W-1:0] a_wdata_o
);
    localparam int LANE_W = LINE_W / 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Y = 2'd1,
`ifdef CUR_LOAD_CHROMA_EN
        LOAD_C = 2'd2,
`endif
        FLUSH  = 2'd3
    } state_t;

    state_t state, state_n;
    logic [7:0] row;
    logic       xfer;
    logic       luma_last;
    logic       busy_n;
    logic       ready_n;

    logic [3:0][LANE_W-1:0] q;
    logic [3:0][LANE_W-1:0] base;
    logic [3:0][LANE_W-1:0] rot;

    assign xfer      = pix_valid_i & pix_ready_o;
    assign luma_last = (row == 8'd127);

    always_comb begin
        state_n = state;
        busy_n  = 1'b1;
        ready_n = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start_i) state_n = LOAD_Y;
            end
            LOAD_Y: begin
                ready_n = 1'b1;
`ifdef CUR_LOAD_CHROMA_EN
                if (xfer && luma_last) state_n = LOAD_C;
`else
                if (xfer && luma_last) state_n = FLUSH;
`endif
            end
`ifdef CUR_LOAD_CHROMA_EN
            LOAD_C: begin
                ready_n = 1'b1;
                if (xfer && row == 8'd191) state_n = FLUSH;
            end
`endif
            FLUSH:   state_n = IDLE;
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy_o      = busy_n;
    assign pix_ready_o = ready_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Start is only honoured from IDLE, so a stray start mid-load never disturbs the row count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          row <= 8'd0;
        else if (state == IDLE && start_i) row <= 8'd0;
        else if (xfer)                     row <= row + 8'd1;
    end

    assign q    = pix_data_i;
    assign base = {q[3], q[1], q[2], q[0]};

    for (genvar j = 0; j < 4; j++) begin : g_lane
        cur_mb_lane_sel #(.LANE_W(LANE_W), .IDX(j)) u_sel (
            .base (base),
            .k    (row[1:0]),
            .lane (rot[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_wen_o   <= 1'b0;
            a_addr_o  <= 8'd0;
            a_wdata_o <= '0;
            done_o    <= 1'b0;
        end else begin
            a_wen_o <= xfer;
            done_o  <= (state == FLUSH);
            if (xfer) begin
                a_addr_o  <= row;
                a_wdata_o <= rot;
            end
        end
    end
endmodule

// File: tb/tb_cur_mb_load_ctrl.sv
// Scoreboard bench for cur_mb_load_ctrl: stimulus queues expected writes/done pulses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_cur_mb_load_ctrl;
    localparam int PIXEL_W = 8;
    localparam int LINE_W  = 32 * PIXEL_W;
`ifdef CUR_LOAD_CHROMA_EN
    localparam int NROWS     = 192;
    localparam int ABORT_ROW = 140;
`else
    localparam int NROWS     = 128;
    localparam int ABORT_ROW = 100;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              pix_valid_i = 1'b0;
    logic [LINE_W-1:0] pix_data_i = '0;
    logic              busy_o, done_o, pix_ready_o, a_wen_o;
    logic [7:0]        a_addr_o;
    logic [LINE_W-1:0] a_wdata_o;

    always #5 clk = ~clk;

    cur_mb_load_ctrl #(.PIXEL_W(PIXEL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .pix_data_i  (pix_data_i),
        .a_wen_o     (a_wen_o),
        .a_addr_o    (a_addr_o),
        .a_wdata_o   (a_wdata_o)
    );

    typedef struct {
        int                due;
        logic [7:0]        addr;
        logic [LINE_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    wr_t mw;
    int  dd;
    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;

    localparam logic [63:0] LA = 64'hA1A2_A3A4_A5A6_A7A8;
    localparam logic [63:0] LB = 64'hB1B2_B3B4_B5B6_B7B8;
    localparam logic [63:0] LC = 64'hC1C2_C3C4_C5C6_C7C8;
    localparam logic [63:0] LD = 64'hD1D2_D3D4_D5D6_D7D8;
    logic [LINE_W-1:0] line0;
    logic [LINE_W-1:0] ht [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [LINE_W-1:0] model(input logic [LINE_W-1:0] d, input int r);
        logic [63:0] q3, q2, q1, q0;
        logic [LINE_W-1:0]   b;
        logic [2*LINE_W-1:0] bb;
        {q3, q2, q1, q0} = d;
        b  = {q3, q1, q2, q0};
        bb = {b, b} >> (64 * (r % 4));
        return bb[LINE_W-1:0];
    endfunction

    function automatic logic [LINE_W-1:0] line_for(input int seed, input int r);
        logic [LINE_W-1:0] l;
        l = line0;
        if (r >= 4)
            for (int i = 0; i < 4; i++)
                l[64*i +: 64] = {16'(seed), 16'(i), 32'(r * 32'h9E37_79B9)};
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] exp_for(input logic [LINE_W-1:0] d, input int r);
        if (r < 4) return ht[r];
        return model(d, r);
    endfunction

    // Monitor: every write and done pulse must match the head of its queue, in the expected cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                mw = exp_q.pop_front();
                chk("wr_cycle_missed", cyc, mw.due);
            end
            if (a_wen_o) begin
                if (exp_q.size() == 0) chk("unexpected_write", a_wen_o, 1'b0);
                else begin
                    mw = exp_q.pop_front();
                    chk("wr_cycle", cyc, mw.due);
                    chk("wr_addr", a_addr_o, mw.addr);
                    chk("wr_data", a_wdata_o, mw.data);
                end
            end
            if (done_q.size() > 0 && done_q[0] < cyc) begin
                dd = done_q.pop_front();
                chk("done_missed", cyc, dd);
            end
            if (done_o) begin
                if (done_q.size() == 0) chk("unexpected_done", done_o, 1'b0);
                else begin
                    dd = done_q.pop_front();
                    chk("done_cycle", cyc, dd);
                    chk("busy_at_done", busy_o, 1'b0);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_ready"}, pix_ready_o, 1'b0);
        chk({tag, "_wen"}, a_wen_o, 1'b0);
        chk({tag, "_addr"}, a_addr_o, 8'd0);
        chk({tag, "_wdata"}, a_wdata_o, '0);
    endtask

    task automatic run_load(input int seed, input int gap, input int start_row,
                            input int abort_row, input bit hold_end, input bit pre);
        int r = 0;
        bit v;
        logic [LINE_W-1:0] d;
        if (!pre) begin
            start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        while (r < NROWS) begin
            if (r == abort_row) begin
                pix_valid_i = 1'b0;
                start_i     = 1'b0;
                rst         = 1'b1;
                #1;
                chk_all_zero("rst_async");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                chk_all_zero("rst_hold");
                rst = 1'b0;
                return;
            end
            v = ($urandom_range(0, 99) >= gap);
            d = line_for(seed, r);
            pix_valid_i = v;
            pix_data_i  = d;
            start_i     = (r == start_row);
            @(negedge clk);
            chk("ready", pix_ready_o, 1'b1);
            chk("busy", busy_o, 1'b1);
            if (v) begin
                exp_q.push_back('{due: cyc + 1, addr: 8'(r), data: exp_for(d, r)});
                if (r == NROWS - 1) done_q.push_back(cyc + 2);
                r++;
            end
            @(posedge clk); #1;
        end
        pix_valid_i = 1'b0;
        start_i     = hold_end;
        @(negedge clk);
        chk("busy_flush", busy_o, 1'b1);
        chk("ready_flush", pix_ready_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_done_cycle", busy_o, 1'b0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("busy_after_done", busy_o, hold_end);
        @(posedge clk); #1;
    endtask

    initial begin
        line0 = {LA, LB, LC, LD};
        ht[0] = {LA, LC, LB, LD};
        ht[1] = {LD, LA, LC, LB};
        ht[2] = {LB, LD, LA, LC};
        ht[3] = {LC, LB, LD, LA};

        #12;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("idle");

        run_load(1, 0, -1, -1, 1'b0, 1'b0);
        run_load(2, 50, 50, -1, 1'b0, 1'b0);
        run_load(3, 0, -1, -1, 1'b1, 1'b0);
        run_load(4, 30, -1, -1, 1'b0, 1'b1);

        run_load(5, 0, -1, ABORT_ROW, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_busy", busy_o, 1'b0);
            chk("post_abort_ready", pix_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        run_load(6, 0, -1, -1, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        chk("pending_writes", exp_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end
endmodule
